// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, divisor width and limits.
// Used by both the transmitter and the receiver.
package uart_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned CPB_W          = 13;
    localparam int unsigned CPB_MIN        = 4;

    typedef enum logic [2:0] {
        StIdle     = 3'b000,
        StStartBit = 3'b001,
        StDataBits = 3'b010,
        StStopBit  = 3'b011,
        StParity   = 3'b100,
        StDone     = 3'b101
    } uart_state_e;

    // Divisors below CPB_MIN leave too few cycles to find mid-bit, so clamp them.
    function automatic logic [CPB_W-1:0] clamp_cpb(input logic [CPB_W-1:0] cpb);
        return (cpb < CPB_W'(CPB_MIN)) ? CPB_W'(CPB_MIN) : cpb;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous rx line; flops reset to the
// idle (high) line level so no false start bit is seen after reset.
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    // Shift the raw line in at the bottom of the chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    end

    // Chain register, synchronous active-low reset to idle-high.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: recovers DATA_WIDTH-bit LSB-first frames from the serial
// line, sampling each bit at mid-period using a divisor captured per frame.
// Optional macro UART_RX_PARITY_EN adds an even-parity bit and parity_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [CPB_W-1:0]      CLKS_PER_BIT,
    input  logic                  rx_serial,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  frame_err,
    output logic                  busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

    localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);

    logic rx_s;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rstn(rstn),
        .d_i (rx_serial),
        .q_o (rx_s)
    );

    uart_state_e           state_q, state_d;
    logic [CPB_W-1:0]      clk_cnt_q, clk_cnt_d;
    logic [CPB_W-1:0]      cpb_q, cpb_d;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_q, valid_d;
    logic                  frame_err_q, frame_err_d;
    logic [CPB_W-1:0]      half_cpb;
    logic                  bit_end;
`ifdef UART_RX_PARITY_EN
    logic                  par_bit_q, par_bit_d;
    logic                  parity_err_q, parity_err_d;
    logic                  par_bad;
`endif

    assign half_cpb = cpb_q >> 1;
    assign bit_end  = (clk_cnt_q == cpb_q - CPB_W'(1));

    // Next-state and datapath updates; pulses default low so they last one cycle.
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        cpb_d       = cpb_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_out_d  = data_out_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
        par_bad      = ^{shift_q, par_bit_q};
`endif
        unique case (state_q)
            StIdle: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                if (!rx_s) begin
                    state_d = StStartBit;
                    cpb_d   = clamp_cpb(CLKS_PER_BIT);
                end
            end
            StStartBit: begin
                if (clk_cnt_q == half_cpb - CPB_W'(1)) begin
                    clk_cnt_d = '0;
                    // Line back high at mid-start means it was only a glitch.
                    state_d   = rx_s ? StIdle : StDataBits;
                end else begin
                    clk_cnt_d = clk_cnt_q + CPB_W'(1);
                end
            end
            StDataBits: begin
                if (bit_end) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_cnt_q] = rx_s;
                    if (bit_cnt_q == LastBit) begin
                        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = StParity;
`else
                        state_d   = StStopBit;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CPB_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    par_bit_d = rx_s;
                    state_d   = StStopBit;
                end else begin
                    clk_cnt_d = clk_cnt_q + CPB_W'(1);
                end
            end
`endif
            StStopBit: begin
                if (bit_end) begin
                    clk_cnt_d   = '0;
                    state_d     = StDone;
                    frame_err_d = ~rx_s;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = par_bad;
                    if (rx_s && !par_bad) begin
                        data_out_d = shift_q;
                        valid_d    = 1'b1;
                    end
`else
                    if (rx_s) begin
                        data_out_d = shift_q;
                        valid_d    = 1'b1;
                    end
`endif
                end else begin
                    clk_cnt_d = clk_cnt_q + CPB_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= StIdle;
            clk_cnt_q    <= '0;
            cpb_q        <= CPB_W'(CPB_MIN);
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            cpb_q        <= cpb_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data_out  = data_out_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: each task drives one scenario and checks inline.
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [12:0] cpb_pin = 13'd16;
    logic        rx = 1'b1;
    logic [7:0]  data_out;
    logic        valid;
    logic        frame_err;
    logic        busy;
`ifdef UART_RX_PARITY_EN
    logic        parity_err;
`endif

    uart_rx dut (
        .clk         (clk),
        .rstn        (rstn),
        .CLKS_PER_BIT(cpb_pin),
        .rx_serial   (rx),
        .data_out    (data_out),
        .valid       (valid),
        .frame_err   (frame_err),
        .busy        (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err  (parity_err)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int last_valid_cyc = 0;
    int frame_start_cyc = 0;
    logic [7:0] rxq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            valid_cnt++;
            rxq.push_back(data_out);
            last_valid_cyc = cyc;
        end
        if (frame_err === 1'b1) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
        if (parity_err === 1'b1) perr_cnt++;
`endif
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one frame starting at a negedge; mid_cpb != 0 perturbs the divisor pin
    // during the data bits and restores it for the stop bit.
    task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop_v,
                              input logic use_par, input logic par_v, input int mid_cpb);
        cpb_pin = 13'(cpb);
        rx = 1'b0;
        frame_start_cyc = cyc;
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == 2 && mid_cpb != 0) cpb_pin = 13'(mid_cpb);
            repeat (cpb) @(negedge clk);
        end
        if (use_par) begin
            rx = par_v;
            repeat (cpb) @(negedge clk);
        end
        rx = stop_v;
        cpb_pin = 13'(cpb);
        repeat (cpb) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data_out: got %h want 00", data_out); end
        n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        int lat;
        send_frame(8'hA5, 16, 1'b1, 1'b0, 1'b0, 0);
        repeat (4) @(negedge clk);
        lat = last_valid_cyc - frame_start_cyc;
        n_cmp++; if (valid_cnt - v0 != 1) begin n_bad++; $display("FAIL basic_pulses: got %0d want 1", valid_cnt - v0); end
        n_cmp++; if (rxq[$] !== 8'hA5) begin n_bad++; $display("FAIL basic_byte: got %h want a5", rxq[$]); end
        n_cmp++; if (data_out !== 8'hA5) begin n_bad++; $display("FAIL basic_hold: got %h want a5", data_out); end
        n_cmp++; if (ferr_cnt != f0) begin n_bad++; $display("FAIL basic_ferr: got %0d want %0d", ferr_cnt, f0); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy: got %b want 0", busy); end
        // 2 + 1 + 8 + 9*16 + 1 = 156, tolerance 1
        n_cmp++; if (lat < 155 || lat > 157) begin n_bad++; $display("FAIL basic_latency: got %0d want 156+-1", lat); end
    endtask

    task automatic test_frame_err();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 0);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        n_cmp++; if (ferr_cnt - f0 != 1) begin n_bad++; $display("FAIL ferr_pulses: got %0d want 1", ferr_cnt - f0); end
        n_cmp++; if (valid_cnt != v0) begin n_bad++; $display("FAIL ferr_valid: got %0d want %0d", valid_cnt, v0); end
        n_cmp++; if (data_out !== 8'hA5) begin n_bad++; $display("FAIL ferr_data_kept: got %h want a5", data_out); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ferr_busy: got %b want 0", busy); end
    endtask

    task automatic test_glitch();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        int k;
        cpb_pin = 13'd16;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_high: got %b want 1", busy); end
        k = 0;
        while (busy !== 1'b0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_drop: got %b want 0 within 10", busy); end
        repeat (5) @(negedge clk);
        n_cmp++; if (valid_cnt != v0 || ferr_cnt != f0) begin
            n_bad++; $display("FAIL glitch_no_pulse: got v%0d f%0d want v%0d f%0d", valid_cnt, ferr_cnt, v0, f0);
        end
    endtask

    task automatic test_back_to_back();
        int v0 = valid_cnt;
        int f0 = ferr_cnt;
        send_frame(8'h00, 4, 1'b1, 1'b0, 1'b0, 100);
        send_frame(8'hFF, 4, 1'b1, 1'b0, 1'b0, 0);
        send_frame(8'h55, 4, 1'b1, 1'b0, 1'b0, 0);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        n_cmp++; if (valid_cnt - v0 != 3) begin n_bad++; $display("FAIL b2b_pulses: got %0d want 3", valid_cnt - v0); end
        n_cmp++; if (rxq[$-2] !== 8'h00) begin n_bad++; $display("FAIL b2b_byte0: got %h want 00", rxq[$-2]); end
        n_cmp++; if (rxq[$-1] !== 8'hFF) begin n_bad++; $display("FAIL b2b_byte1: got %h want ff", rxq[$-1]); end
        n_cmp++; if (rxq[$] !== 8'h55) begin n_bad++; $display("FAIL b2b_byte2: got %h want 55", rxq[$]); end
        n_cmp++; if (ferr_cnt != f0) begin n_bad++; $display("FAIL b2b_ferr: got %0d want %0d", ferr_cnt, f0); end
    endtask

    task automatic test_reset_midframe();
        int v0 = valid_cnt;
        logic [7:0] b = 8'h81;
        cpb_pin = 13'd16;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = b[i];
            repeat (16) @(negedge clk);
        end
        rx = b[3];
        repeat (8) @(negedge clk);
        rstn = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        n_cmp++; if (data_out !== 8'h00) begin n_bad++; $display("FAIL midrst_data_out: got %h want 00", data_out); end
        n_cmp++; if (valid !== 1'b0 || frame_err !== 1'b0) begin
            n_bad++; $display("FAIL midrst_pulses: got v%b f%b want v0 f0", valid, frame_err);
        end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h81, 16, 1'b1, 1'b0, 1'b0, 0);
        repeat (4) @(negedge clk);
        n_cmp++; if (valid_cnt - v0 != 1) begin n_bad++; $display("FAIL midrst_pulses_after: got %0d want 1", valid_cnt - v0); end
        n_cmp++; if (data_out !== 8'h81) begin n_bad++; $display("FAIL midrst_rx81: got %h want 81", data_out); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int v0 = valid_cnt;
        int p0 = perr_cnt;
        // 0x07 has three ones: parity bit 0 is wrong, 1 is right.
        send_frame(8'h07, 16, 1'b1, 1'b1, 1'b0, 0);
        repeat (4) @(negedge clk);
        n_cmp++; if (perr_cnt - p0 != 1) begin n_bad++; $display("FAIL par_err_pulse: got %0d want 1", perr_cnt - p0); end
        n_cmp++; if (valid_cnt != v0) begin n_bad++; $display("FAIL par_err_valid: got %0d want %0d", valid_cnt, v0); end
        send_frame(8'h07, 16, 1'b1, 1'b1, 1'b1, 0);
        repeat (4) @(negedge clk);
        n_cmp++; if (perr_cnt - p0 != 1) begin n_bad++; $display("FAIL par_ok_noerr: got %0d want 1", perr_cnt - p0); end
        n_cmp++; if (data_out !== 8'h07) begin n_bad++; $display("FAIL par_ok_data: got %h want 07", data_out); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receiver stage that consumes the 8N1 line produced by the team's UART transmitter and recovers parallel bytes. It synchronises the asynchronous rx line, finds the start bit, and samples each bit at mid-period using the same runtime CLKS_PER_BIT divisor as the transmitter. It delivers each byte with a one-cycle valid pulse, or a one-cycle frame_err pulse, to the downstream consumer.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame, LSB first.
- SYNC_STAGES, 2, flops in the rx input synchroniser; minimum 2.

Ports:
- clk  input  1  clock; all logic on posedge.
- rstn  input  1  synchronous, active-low reset.
- CLKS_PER_BIT  input  13  clk cycles per bit; captured at start-bit detect.
- rx_serial  input  1  asynchronous serial line; idle high.
- data_out  output  DATA_WIDTH  last good byte; held until the next good frame.
- valid  output  1  one-cycle pulse; data_out updated in the same cycle.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rstn=0 at posedge):
  - state=IDLE; data_out=0; valid=0; frame_err=0; busy=0.
  - Counters cleared; synchroniser flops set to 1.
  - Applies mid-frame; a partial byte is discarded with no pulse.
- Synchroniser: rx_s is rx_serial delayed SYNC_STAGES cycles. All decisions use rx_s only.
- Divisor capture: cpb_r <= CLKS_PER_BIT on the IDLE->START_BIT transition. Values <4 are captured as 4. Changes to CLKS_PER_BIT mid-frame have no effect.
- Counters: clk_cnt is 13 bits; bit_cnt is clog2(DATA_WIDTH) bits.
- State encoding: IDLE=000, START_BIT=001, DATA_BITS=010, STOP_BIT=011, DONE=101.
- IDLE: clk_cnt=0, bit_cnt=0. If rx_s==0, go to START_BIT.
- START_BIT: count to (cpb_r>>1)-1 (mid-bit).
  - If rx_s==1 there: glitch; go to IDLE with no pulse.
  - Otherwise clk_cnt=0 and go to DATA_BITS.
- DATA_BITS: count to cpb_r-1.
  - At terminal count: shift_reg[bit_cnt] <= rx_s and clk_cnt=0.
  - After bit DATA_WIDTH-1 go to STOP_BIT; otherwise bit_cnt+1.
- STOP_BIT: count to cpb_r-1, then sample rx_s.
  - If 1: data_out <= shift_reg and valid=1 in the next cycle.
  - If 0: frame_err=1 in the next cycle; data_out unchanged.
  - Go to DONE in both cases.
- DONE: exactly one cycle, then IDLE. valid or frame_err is high only in this cycle.
- Back-to-back frames: a start bit arriving on the cycle after DONE is detected; no dead time beyond DONE.
- Line held low continuously:
  - Produces a frame with data 0x00 and frame_err.
  - Then re-enters START_BIT immediately from IDLE, since rx_s is still 0.
- Timing: from the start-bit falling edge at rx_serial to valid is SYNC_STAGES + 1 + (cpb_r>>1) + (DATA_WIDTH+1)*cpb_r + 1 cycles, ±1.

Optional Feature:
- UART_RX_PARITY_EN defined:
  - A PARITY state (encoding 100) is inserted between DATA_BITS and STOP_BIT and lasts one bit period. It samples the parity bit.
  - Even parity: XOR of data bits plus parity bit must equal 0.
  - Extra output port parity_err (1 bit) pulses in DONE on mismatch. data_out is not updated; valid stays low.
  - Frame and parity errors may pulse together.
- Undefined: no PARITY state, no parity_err port, 8N1 only.

Decomposition:
- Package uart_pkg:
  - State localparams (IDLE, START_BIT, DATA_BITS, STOP_BIT, PARITY, DONE).
  - DATA_WIDTH default; CPB_W=13; CPB_MIN=4.
  - The package is shared with the transmitter.
- Sub-module uart_rx_sync: SYNC_STAGES-deep flop chain, reset to 1.

Test Plan:
- CLKS_PER_BIT=16, send 0xA5 (8N1) -> data_out=0xA5; single valid pulse; frame_err=0; busy low after DONE.
- CLKS_PER_BIT=16, stop bit driven 0, byte 0x3C -> frame_err pulse; valid=0; data_out keeps the previous value.
- rx low for 5 cycles at CLKS_PER_BIT=16, then high -> returns to IDLE; no pulse; busy drops within 10 cycles.
- Back-to-back 0x00, 0xFF, 0x55 at CLKS_PER_BIT=4 -> three valid pulses in order; CLKS_PER_BIT changed to 100 mid-frame does not affect the current frame.
- rstn asserted during bit 3 of 0x81 -> all outputs at reset values next cycle; a following 0x81 is received correctly.
- UART_RX_PARITY_EN: 0x07 with parity bit 0 -> parity_err pulse, valid=0; with parity bit 1 -> valid, data_out=0x07.
